wb_cmd_master: RTL and testbench

WB_CMD_MASTER -- requirements
Module: wb_cmd_master

---
 rtl/wb_cmd_master.sv | 134 +++++++++++++
 tb/tb_wb_cmd_master.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master.sv
// Single-command Wishbone classic initiator: one command in, one bus cycle, one response out.
// Optional watchdog on the bus phase is compiled in with `define WB_CMD_MASTER_TIMEOUT_EN.
module wb_cmd_master #(
  parameter int WB_AW          = 32,
  parameter int WB_DW          = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic               cmd_we_i,
  input  logic [WB_AW-1:0]   cmd_adr_i,
  input  logic [WB_DW-1:0]   cmd_dat_i,
  input  logic [WB_DW/8-1:0] cmd_sel_i,
  output logic               rsp_valid_o,
  output logic [WB_DW-1:0]   rsp_dat_o,
  output logic               rsp_err_o,
  output logic               rsp_tmo_o,
  output logic [WB_AW-1:0]   wb_adr_o,
  output logic [WB_DW-1:0]   wb_dat_o,
  output logic [WB_DW/8-1:0] wb_sel_o,
  output logic               wb_we_o,
  output logic               wb_cyc_o,
  output logic               wb_stb_o,
  output logic [2:0]         wb_cti_o,
  output logic [1:0]         wb_bte_o,
  input  logic [WB_DW-1:0]   wb_dat_i,
  input  logic               wb_ack_i,
  input  logic               wb_err_i
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  state_t state;

  logic             bus_done;
  logic             nxt_err;
  logic [WB_DW-1:0] nxt_dat;

  assign cmd_ready_o = wb_rst_ni && (state == IDLE);
  assign wb_cti_o    = 3'b000;
  assign wb_bte_o    = 2'b00;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        tmo_hit;
  logic        nxt_tmo;
  logic        rsp_tmo_q;
  // Abort on the TIMEOUT_CYCLES-th bus cycle that sees no termination.
  assign tmo_hit   = (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign rsp_tmo_o = rsp_tmo_q;
`else
  assign rsp_tmo_o = 1'b0;
`endif

  // Termination priority: err, then ack, then watchdog.
  always_comb begin
    bus_done = 1'b0;
    nxt_err  = 1'b0;
    nxt_dat  = '0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
    nxt_tmo  = 1'b0;
`endif
    if (wb_err_i) begin
      bus_done = 1'b1;
      nxt_err  = 1'b1;
    end else if (wb_ack_i) begin
      bus_done = 1'b1;
      nxt_dat  = wb_we_o ? '0 : wb_dat_i;
    end
`ifdef WB_CMD_MASTER_TIMEOUT_EN
    else if (tmo_hit) begin
      bus_done = 1'b1;
      nxt_err  = 1'b1;
      nxt_tmo  = 1'b1;
    end
`endif
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state       <= IDLE;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_adr_o    <= '0;
      wb_dat_o    <= '0;
      wb_sel_o    <= '0;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_dat_o   <= '0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
      rsp_tmo_q   <= 1'b0;
      tmo_cnt     <= '0;
`endif
    end else begin
      rsp_valid_o <= 1'b0;
      case (state)
        IDLE: if (cmd_valid_i) begin
          state    <= BUS;
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
          wb_we_o  <= cmd_we_i;
          wb_adr_o <= cmd_adr_i;
          wb_dat_o <= cmd_dat_i;
          wb_sel_o <= cmd_sel_i;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
          tmo_cnt  <= '0;
`endif
        end
        BUS: if (bus_done) begin
          state       <= RESP;
          wb_cyc_o    <= 1'b0;
          wb_stb_o    <= 1'b0;
          wb_we_o     <= 1'b0;
          wb_adr_o    <= '0;
          wb_dat_o    <= '0;
          wb_sel_o    <= '0;
          rsp_valid_o <= 1'b1;
          rsp_err_o   <= nxt_err;
          rsp_dat_o   <= nxt_dat;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
          rsp_tmo_q   <= nxt_tmo;
        end else begin
          tmo_cnt     <= tmo_cnt + 16'd1;
`endif
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master: behavioural Wishbone responder plus a response scoreboard.
module tb_wb_cmd_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0, cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid, rsp_err, rsp_tmo;
  logic [31:0] rsp_dat;
  logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_cyc, wb_stb, wb_ack, wb_err;
  logic [2:0]  wb_cti;
  logic [1:0]  wb_bte;

  always #5 clk = ~clk;

  wb_cmd_master #(.WB_AW(32), .WB_DW(32), .TIMEOUT_CYCLES(8)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_we_i(cmd_we), .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err), .rsp_tmo_o(rsp_tmo),
    .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel), .wb_we_o(wb_we),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_cti_o(wb_cti), .wb_bte_o(wb_bte),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack), .wb_err_i(wb_err)
  );

  // Responder: terminates after ack_wait wait states; mode 0 ack, 1 err, 2 both, 3 never.
  int          ack_wait = 0, resp_mode = 3, wcnt = 0;
  logic [31:0] rdata = '0;
  logic        stray_ack = 1'b0;
  logic        hit;
  always @(posedge clk) wcnt <= (wb_cyc && wb_stb) ? wcnt + 1 : 0;
  assign hit      = wb_cyc && wb_stb && (wcnt == ack_wait) && (resp_mode != 3);
  assign wb_ack   = (hit && (resp_mode == 0 || resp_mode == 2)) || stray_ack;
  assign wb_err   = hit && (resp_mode == 1 || resp_mode == 2);
  assign wb_dat_i = hit ? rdata : 32'hBAD0_BAD0;

  typedef struct {logic [31:0] dat; logic err; logic tmo;} exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One command end to end. Payload inputs are scrambled and valid held high while busy,
  // so any sampling outside IDLE shows up as bus-side instability.
  task automatic do_cmd(input string tag, input logic we, input logic [31:0] adr, dat,
                        input logic [3:0] sel, input int wait_n, mode, input logic [31:0] rdat,
                        input logic [31:0] edat, input logic eerr, etmo, input int ecyc, elat);
    int   ncyc, lat;
    logic stable;
    exp_t e;
    ack_wait = wait_n; resp_mode = mode; rdata = rdat;
    sb.push_back('{dat: edat, err: eerr, tmo: etmo});
    cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_valid = 1'b1;
    chk({tag, ".ready_idle"}, 64'(cmd_ready), 64'd1);
    step();
    cmd_we = ~we; cmd_adr = ~adr; cmd_dat = ~dat; cmd_sel = ~sel;
    chk({tag, ".bus_ctl"}, {61'd0, wb_cyc, wb_stb, wb_we}, {61'd0, 1'b1, 1'b1, we});
    chk({tag, ".bus_adr"}, 64'(wb_adr), 64'(adr));
    chk({tag, ".bus_dat_sel"}, {28'd0, wb_sel, wb_dat_o}, {28'd0, sel, dat});
    ncyc = 0; lat = 1; stable = 1'b1;
    while (!rsp_valid && lat < 2000) begin
      if (wb_cyc) begin
        ncyc++;
        if (wb_adr !== adr || wb_dat_o !== dat || wb_sel !== sel || wb_we !== we ||
            !wb_stb || cmd_ready) stable = 1'b0;
      end
      step();
      lat++;
    end
    cmd_valid = 1'b0;
    chk({tag, ".bus_stable"}, 64'(stable), 64'd1);
    chk({tag, ".cyc_cycles"}, 64'(ncyc), 64'(ecyc));
    chk({tag, ".rsp_latency"}, 64'(lat), 64'(elat));
    if (sb.size() == 0) chk({tag, ".sb_empty"}, 64'(sb.size()), 64'd1);
    else begin
      e = sb.pop_front();
      chk({tag, ".rsp_dat"}, 64'(rsp_dat), 64'(e.dat));
      chk({tag, ".rsp_err_tmo"}, {62'd0, rsp_err, rsp_tmo}, {62'd0, e.err, e.tmo});
      chk({tag, ".cyc_low_at_rsp"}, {62'd0, wb_cyc, wb_stb}, 64'd0);
      step();
      chk({tag, ".rsp_one_cycle"}, 64'(rsp_valid), 64'd0);
      chk({tag, ".rsp_hold"}, {31'd0, rsp_err, rsp_dat}, {31'd0, e.err, e.dat});
      chk({tag, ".ready_next"}, 64'(cmd_ready), 64'd1);
      chk({tag, ".idle_dat_sel"}, {28'd0, wb_sel, wb_dat_o}, 64'd0);
    end
  endtask

  initial begin
    logic ok;
    // Reset
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst.ready_low", 64'(cmd_ready), 64'd0);
    end
    chk("rst.bus", {59'd0, wb_cyc, wb_stb, wb_we, wb_sel}, 64'd0);
    chk("rst.adr_dat", {wb_adr, wb_dat_o}, 64'd0);
    chk("rst.rsp", {29'd0, rsp_valid, rsp_err, rsp_tmo, rsp_dat}, 64'd0);
    chk("rst.cti_bte", {59'd0, wb_cti, wb_bte}, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rst.ready_release", 64'(cmd_ready), 64'd1);
    step();

    // Write with one wait state: two bus cycles, response data zero
    do_cmd("wr1", 1'b1, 32'h0, 32'hDEAD_BEEF, 4'hF, 1, 0, 32'h0,
           32'h0, 1'b0, 1'b0, 2, 3);
    // Zero-wait read: response in the third cycle counting the accept cycle
    do_cmd("rd0", 1'b0, 32'h4, 32'h0, 4'hF, 0, 0, 32'h1234_5678,
           32'h1234_5678, 1'b0, 1'b0, 1, 2);
    // ack and err together: err wins, data forced to zero
    do_cmd("rd_ackerr", 1'b0, 32'h8, 32'h0, 4'hF, 0, 2, 32'hCAFE_F00D,
           32'h0, 1'b1, 1'b0, 1, 2);
    // Read, two waits, partial select
    do_cmd("rd2", 1'b0, 32'h100, 32'h5555_AAAA, 4'b0011, 2, 0, 32'hA5A5_5A5A,
           32'hA5A5_5A5A, 1'b0, 1'b0, 3, 4);
    // Write terminated by err alone
    do_cmd("wr_err", 1'b1, 32'hFFFF_FFFC, 32'h0F0F_0F0F, 4'b1000, 0, 1, 32'h0,
           32'h0, 1'b1, 1'b0, 1, 2);

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    do_cmd("tmo", 1'b0, 32'h20, 32'h0, 4'hF, 0, 3, 32'h0,
           32'h0, 1'b1, 1'b1, 8, 9);
`else
    // No watchdog: bus cycle stays open indefinitely
    resp_mode = 3; cmd_we = 1'b0; cmd_adr = 32'h20; cmd_sel = 4'hF; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (!wb_cyc || !wb_stb || rsp_valid) ok = 1'b0;
      step();
    end
    chk("no_tmo.cyc_held", 64'(ok), 64'd1);
    chk("no_tmo.rsp_tmo", 64'(rsp_tmo), 64'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
`endif

    // Reset three cycles into the bus phase abandons the cycle silently
    resp_mode = 3; cmd_we = 1'b1; cmd_adr = 32'h40; cmd_dat = 32'h1111_2222; cmd_sel = 4'hF;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step(); step();
    chk("rst_bus.in_bus", {62'd0, wb_cyc, wb_stb}, 64'd3);
    rst_n = 1'b0;
    step();
    chk("rst_bus.cyc_low", {60'd0, wb_cyc, wb_stb, rsp_valid, cmd_ready}, 64'd0);
    chk("rst_bus.dat_sel", {28'd0, wb_sel, wb_dat_o}, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_bus.ready", 64'(cmd_ready), 64'd1);
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (rsp_valid || wb_cyc) ok = 1'b0;
    end
    chk("rst_bus.no_rsp", 64'(ok), 64'd1);

    // Stray ack while idle is ignored
    stray_ack = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (rsp_valid || !cmd_ready || wb_cyc) ok = 1'b0;
    end
    stray_ack = 1'b0;
    chk("stray_ack.idle", 64'(ok), 64'd1);

    // Normal operation after all of the above
    do_cmd("rd_final", 1'b0, 32'h44, 32'h0, 4'b0110, 1, 0, 32'h0BAD_CAFE,
           32'h0BAD_CAFE, 1'b0, 1'b0, 2, 3);
    chk("sb.drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
